// File: rtl/lane_key_scheduler.sv
// rtl/lane_key_scheduler.sv - PS/2 scancode parser, 8-key held tracker and lane event FIFO
module lane_key_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  KEY0 = 8'h23,
    parameter logic [7:0]  KEY1 = 8'h2B,
    parameter logic [7:0]  KEY2 = 8'h3B,
    parameter logic [7:0]  KEY3 = 8'h42,
    parameter logic [7:0]  ALT0 = 8'h6B,
    parameter logic [7:0]  ALT1 = 8'h72,
    parameter logic [7:0]  ALT2 = 8'h75,
    parameter logic [7:0]  ALT3 = 8'h74
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_lane,
    output logic       evt_press,
    output logic [3:0] lane_held,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] MAIN_TAB [4] = '{KEY0, KEY1, KEY2, KEY3};
    localparam logic [7:0] ALT_TAB  [4] = '{ALT0, ALT1, ALT2, ALT3};

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    state_t     state, state_next;
    logic [2:0] skip_cnt, skip_cnt_next;
    logic       code_hit, code_ext, code_make;
    logic       key_match;
    logic [2:0] key_idx;

    logic       act_valid, act_make;
    logic [2:0] act_idx;

    // bits 3:0 main keys, bits 7:4 alternate arrows of the same lanes
    logic [7:0] key_held, key_held_next;
    logic [3:0] lane_next, lane_diff;
    logic       push, push_press;
    logic [1:0] push_lane;

    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, pop, do_push, drop, overflow_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        skip_cnt_next = skip_cnt;
        code_hit      = 1'b0;
        code_ext      = 1'b0;
        code_make     = 1'b0;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == 8'hE0)      state_next = S_EXT;
                    else if (byte_data == 8'hF0) state_next = S_BRK;
                    else if (byte_data == 8'hE1) begin
                        state_next    = S_SKIP;
                        skip_cnt_next = 3'd7;
                    end else begin
                        code_hit  = 1'b1;
                        code_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_data == 8'hF0)      state_next = S_EXT_BRK;
                    else if (byte_data != 8'hE0) begin
                        code_hit   = 1'b1;
                        code_make  = 1'b1;
                        code_ext   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    code_hit   = 1'b1;
                    state_next = S_IDLE;
                end
                S_EXT_BRK: begin
                    code_hit   = 1'b1;
                    code_ext   = 1'b1;
                    state_next = S_IDLE;
                end
                S_SKIP: begin
                    skip_cnt_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_match = 1'b0;
        key_idx   = '0;
        if (code_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (!key_match && byte_data == (code_ext ? ALT_TAB[i] : MAIN_TAB[i])) begin
                    key_match = 1'b1;
                    key_idx   = {code_ext, 2'(i)};
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            act_valid <= 1'b0;
            act_make  <= 1'b0;
            act_idx   <= '0;
        end else begin
            act_valid <= key_match;
            act_make  <= code_make;
            act_idx   <= key_idx;
        end
    end

    // an event is generated only when the lane-level OR of its two keys changes
    always_comb begin
        key_held_next = key_held;
        if (act_valid) key_held_next[act_idx] = act_make;
        lane_next  = key_held_next[3:0] | key_held_next[7:4];
        lane_diff  = lane_next ^ lane_held;
        push       = |lane_diff;
        push_press = |(lane_next & lane_diff);
        push_lane  = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_diff[i]) push_lane = 2'(i);
        end
    end

    assign lane_held = key_held[3:0] | key_held[7:4];

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = evt_valid & evt_ready;
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            key_held   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            key_held <= key_held_next;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= {push_lane, push_press};
    end

    assign evt_valid = (count != '0);
    assign evt_lane  = evt_valid ? mem[rd_ptr][2:1] : 2'b00;
    assign evt_press = evt_valid ? mem[rd_ptr][0]   : 1'b0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_lane_key_scheduler.sv
// tb/tb_lane_key_scheduler.sv - directed vector bench for lane_key_scheduler
module tb_lane_key_scheduler;
    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid, evt_press, overflow;
    logic [1:0] evt_lane;
    logic [3:0] lane_held;

    int checks = 0;
    int errors = 0;

    lane_key_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_lane(evt_lane),
        .evt_press(evt_press), .lane_held(lane_held), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        logic       ev;
        logic [1:0] lane;
        logic       press;
        logic [3:0] held;
    } vec_t;

    typedef struct {
        logic [1:0] lane;
        logic       press;
    } evt_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic ev, input logic [1:0] lane,
                                input logic press, input logic [3:0] held);
        vec_t v;
        v.data = d; v.ev = ev; v.lane = lane; v.press = press; v.held = held;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic pop_one;
        evt_ready = 1'b1;
        tick;
        evt_ready = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [1:0] lane, input logic press);
        check({name, " valid"}, 8'(evt_valid), 8'h01);
        check({name, " lane"},  8'(evt_lane),  8'(lane));
        check({name, " press"}, 8'(evt_press), 8'(press));
        pop_one;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " evt_valid"}, 8'(evt_valid), 8'h00);
        check({name, " evt_lane"},  8'(evt_lane),  8'h00);
        check({name, " evt_press"}, 8'(evt_press), 8'h00);
        check({name, " lane_held"}, 8'(lane_held), 8'h00);
        check({name, " overflow"},  8'(overflow),  8'h00);
    endtask

    evt_t exp_q[$];

    initial begin
        // basic make/break
        vecs.push_back(mk(8'h23, 1, 2'd0, 1, 4'b0001));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0001));
        vecs.push_back(mk(8'h23, 1, 2'd0, 0, 4'b0000));
        // alt + main on one lane
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h74, 1, 2'd3, 1, 4'b1000));
        vecs.push_back(mk(8'h42, 0, 2'd0, 0, 4'b1000));
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b1000));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b1000));
        vecs.push_back(mk(8'h74, 0, 2'd0, 0, 4'b1000));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b1000));
        vecs.push_back(mk(8'h42, 1, 2'd3, 0, 4'b0000));
        // typematic repeat
        vecs.push_back(mk(8'h2B, 1, 2'd1, 1, 4'b0010));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(8'h2B, 0, 2'd0, 0, 4'b0010));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0010));
        vecs.push_back(mk(8'h2B, 1, 2'd1, 0, 4'b0000));
        // pause sequence swallowed
        vecs.push_back(mk(8'hE1, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h14, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h77, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'hE1, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h14, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h77, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h3B, 1, 2'd2, 1, 4'b0100));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0100));
        vecs.push_back(mk(8'h3B, 1, 2'd2, 0, 4'b0000));
        // unmatched codes: fake shift, extended D, non-extended arrow
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h12, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h23, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h6B, 0, 2'd0, 0, 4'b0000));
        // doubled E0 then left arrow, extended break
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0000));
        vecs.push_back(mk(8'h6B, 1, 2'd0, 1, 4'b0001));
        vecs.push_back(mk(8'hE0, 0, 2'd0, 0, 4'b0001));
        vecs.push_back(mk(8'hF0, 0, 2'd0, 0, 4'b0001));
        vecs.push_back(mk(8'h6B, 1, 2'd0, 0, 4'b0000));

        tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;

        // latency: event absent one cycle after the byte, present two cycles after
        send(8'h23);
        check("lat0 early", 8'(evt_valid), 8'h00);
        tick;
        expect_head("lat0", 2'd0, 1'b1);
        check("lat0 held", 8'(lane_held), 8'h01);
        send(8'hF0);
        send(8'h23);
        check("lat1 early", 8'(evt_valid), 8'h00);
        tick;
        expect_head("lat1", 2'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].data);
            tick;
            check($sformatf("v%0d valid", i), 8'(evt_valid), 8'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("v%0d lane", i),  8'(evt_lane),  8'(vecs[i].lane));
                check($sformatf("v%0d press", i), 8'(evt_press), 8'(vecs[i].press));
                pop_one;
            end
            check($sformatf("v%0d held", i), 8'(lane_held), 8'(vecs[i].held));
        end

        // overflow: six transitions into a 4-deep queue with no consumer
        send(8'h23); send(8'h2B); send(8'h3B); send(8'h42);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h2B);
        tick;
        check("ovf flag", 8'(overflow), 8'h01);
        check("ovf held", 8'(lane_held), 8'h0C);
        clr_overflow = 1'b1;
        tick;
        clr_overflow = 1'b0;
        check("ovf clr", 8'(overflow), 8'h00);

        // push and pop together while full: nothing dropped
        send(8'hF0);
        byte_valid = 1'b1;
        byte_data  = 8'h3B;
        tick;
        byte_valid = 1'b0;
        evt_ready  = 1'b1;
        tick;
        evt_ready  = 1'b0;
        check("full pp overflow", 8'(overflow), 8'h00);
        exp_q.push_back('{2'd1, 1'b1});
        exp_q.push_back('{2'd2, 1'b1});
        exp_q.push_back('{2'd3, 1'b1});
        exp_q.push_back('{2'd2, 1'b0});
        for (int i = 0; i < exp_q.size(); i++)
            expect_head($sformatf("drain%0d", i), exp_q[i].lane, exp_q[i].press);
        check("drain empty", 8'(evt_valid), 8'h00);
        check("drain held", 8'(lane_held), 8'h08);

        // reset in the middle of an extended prefix
        send(8'hE0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick;
        rst = 1'b0;
        send(8'h23);
        tick;
        expect_head("postrst", 2'd0, 1'b1);
        check("postrst held", 8'(lane_held), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
